// File: rtl/vcache_stat_array.sv
// Per-bank vcache event counters (ld, st, ld_miss, st_miss; +miss_cycles with VCACHE_STAT_MISS_LATENCY_EN) with snapshot readout.
// Latency: first readout entry one cycle after the snapshot handshake, then one entry per accepted beat.
// Backpressure: out_* held while out_ready_i is low; snapshot requests are refused (snap_ready_o=0) while draining.
module vcache_stat_array #(
    parameter int num_banks_p     = 8,
    parameter int counter_width_p = 32,
    parameter int tag_width_p     = 32,
    localparam int bank_width_lp  = (num_banks_p > 1) ? $clog2(num_banks_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [num_banks_p-1:0]     resp_v_i,
    input  logic [num_banks_p-1:0]     resp_st_i,
    input  logic [num_banks_p-1:0]     resp_miss_i,
    input  logic [num_banks_p-1:0]     miss_busy_i,
    input  logic                       clear_i,
    input  logic                       snap_v_i,
    input  logic [tag_width_p-1:0]     snap_tag_i,
    output logic                       snap_ready_o,
    output logic                       out_v_o,
    input  logic                       out_ready_i,
    output logic [bank_width_lp-1:0]   out_bank_o,
    output logic [2:0]                 out_event_o,
    output logic [counter_width_p-1:0] out_count_o,
    output logic [tag_width_p-1:0]     out_tag_o,
    output logic                       out_last_o
);

`ifdef VCACHE_STAT_MISS_LATENCY_EN
    localparam int num_events_lp = 5;
`else
    localparam int num_events_lp = 4;
    logic unused_miss_busy;
    assign unused_miss_busy = ^miss_busy_i;
`endif

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [bank_width_lp-1:0] last_bank_lp = bank_width_lp'(num_banks_p - 1);
    localparam logic [2:0]               last_evt_lp  = 3'(num_events_lp - 1);

    typedef logic [counter_width_p-1:0] cnt_t;

    cnt_t                     live_r   [num_banks_p][num_events_lp];
    cnt_t                     shadow_r [num_banks_p][num_events_lp];
    logic [num_events_lp-1:0] inc      [num_banks_p];

    logic [0:0]               state_r;
    logic [bank_width_lp-1:0] bank_r;
    logic [2:0]               evt_r;
    logic [tag_width_p-1:0]   tag_r;
    logic                     snap_fire;
    logic                     out_fire;
    logic                     at_last;

    always_comb begin
        for (int b = 0; b < num_banks_p; b++) begin
            inc[b]    = '0;
            inc[b][0] = resp_v_i[b] & ~resp_st_i[b];
            inc[b][1] = resp_v_i[b] &  resp_st_i[b];
            inc[b][2] = resp_v_i[b] & ~resp_st_i[b] & resp_miss_i[b];
            inc[b][3] = resp_v_i[b] &  resp_st_i[b] & resp_miss_i[b];
`ifdef VCACHE_STAT_MISS_LATENCY_EN
            inc[b][4] = miss_busy_i[b];
`endif
        end
    end

    // Clear wins over increments; counters stick at all-ones.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int b = 0; b < num_banks_p; b++)
                for (int e = 0; e < num_events_lp; e++)
                    live_r[b][e] <= '0;
        end else begin
            for (int b = 0; b < num_banks_p; b++)
                for (int e = 0; e < num_events_lp; e++)
                    if (clear_i)
                        live_r[b][e] <= '0;
                    else if (inc[b][e] && (live_r[b][e] != '1))
                        live_r[b][e] <= live_r[b][e] + cnt_t'(1);
        end
    end

    assign snap_ready_o = (state_r == IDLE);
    assign out_v_o      = (state_r == DRAIN);
    assign snap_fire    = snap_v_i & snap_ready_o;
    assign out_fire     = out_v_o & out_ready_i;
    assign at_last      = (bank_r == last_bank_lp) && (evt_r == last_evt_lp);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            bank_r  <= '0;
            evt_r   <= '0;
            tag_r   <= '0;
            for (int b = 0; b < num_banks_p; b++)
                for (int e = 0; e < num_events_lp; e++)
                    shadow_r[b][e] <= '0;
        end else if (snap_fire) begin
            // Shadow takes the pre-increment, pre-clear live values.
            state_r <= DRAIN;
            bank_r  <= '0;
            evt_r   <= '0;
            tag_r   <= snap_tag_i;
            for (int b = 0; b < num_banks_p; b++)
                for (int e = 0; e < num_events_lp; e++)
                    shadow_r[b][e] <= live_r[b][e];
        end else if (out_fire) begin
            if (at_last) begin
                state_r <= IDLE;
                bank_r  <= '0;
                evt_r   <= '0;
            end else if (evt_r == last_evt_lp) begin
                evt_r  <= '0;
                bank_r <= bank_r + 1'b1;
            end else begin
                evt_r <= evt_r + 3'd1;
            end
        end
    end

    always_comb begin
        out_count_o = '0;
        for (int b = 0; b < num_banks_p; b++)
            for (int e = 0; e < num_events_lp; e++)
                if ((bank_r == bank_width_lp'(b)) && (evt_r == 3'(e)))
                    out_count_o = shadow_r[b][e];
    end

    assign out_bank_o  = bank_r;
    assign out_event_o = evt_r;
    assign out_tag_o   = tag_r;
    assign out_last_o  = out_v_o & at_last;

endmodule
